// File: rtl/stump_mem_arbiter_if.sv
// Bus bundle between the two Stump memory requesters, the arbiter and the memory model.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface stump_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // Handshake: a requester raises mX_req with wen/addr/wdata stable and holds all of
    // them until mX_ack, a single-cycle pulse; for reads mX_rdata is valid with that ack
    // and held until the next ack to the same requester.
    logic              m0_req;
    logic              m0_wen;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_wen;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_lock;

    logic              cpu_stall;
    logic              grant_id;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wen;
    logic              mem_ren;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_wen, m0_addr, m0_wdata,
        input  m1_req, m1_wen, m1_addr, m1_wdata, m1_lock,
        input  mem_rdata,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output cpu_stall, grant_id,
        output mem_addr, mem_wdata, mem_wen, mem_ren
    );

    modport master (
        output m0_req, m0_wen, m0_addr, m0_wdata,
        output m1_req, m1_wen, m1_addr, m1_wdata, m1_lock,
        output mem_rdata,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  cpu_stall, grant_id,
        input  mem_addr, mem_wdata, mem_wen, mem_ren
    );
endinterface

// File: rtl/stump_mem_arbiter.sv
// Two-master round-robin arbiter for the single Stump memory port (IDLE -> ACCESS -> RESP).
// Define STUMP_ARB_LOCK_EN to let master 1 hold the port across a locked burst.
module stump_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    stump_mem_arbiter_if.slave   bus,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              last_q;
    logic              gid_q;
    logic              wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;

    logic              win_valid;
    logic              win_id;

`ifdef STUMP_ARB_LOCK_EN
    logic              lock_q;
    logic              lock_lat_q;
`else
    logic              unused_lock;
    assign unused_lock = bus.m1_lock;
`endif

    // Arbitration: a lone requester wins; on a tie the master that did not go last wins.
    always_comb begin
        win_valid = bus.m0_req | bus.m1_req;
        win_id    = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
            win_id = ~last_q;
        end else if (bus.m1_req) begin
            win_id = 1'b1;
        end
`ifdef STUMP_ARB_LOCK_EN
        if (lock_q && bus.m1_req) begin
            win_id = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_valid) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latches and read-data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= 1'b1;
            gid_q      <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        gid_q   <= win_id;
                        wen_q   <= win_id ? bus.m1_wen   : bus.m0_wen;
                        addr_q  <= win_id ? bus.m1_addr  : bus.m0_addr;
                        wdata_q <= win_id ? bus.m1_wdata : bus.m0_wdata;
                    end
                end
                ACCESS: begin
                    last_q <= gid_q;
                    if (!wen_q) begin
                        if (gid_q) begin
                            m1_rdata_q <= bus.mem_rdata;
                        end else begin
                            m0_rdata_q <= bus.mem_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef STUMP_ARB_LOCK_EN
    // The lock request travels with the granted access and takes effect when it completes;
    // master 1 releases it by finishing an unlocked access or by leaving req low in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q     <= 1'b0;
            lock_lat_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        lock_lat_q <= win_id & bus.m1_lock;
                    end
                    if (lock_q && !bus.m1_req) begin
                        lock_q <= 1'b0;
                    end
                end
                RESP: begin
                    if (gid_q) begin
                        lock_q <= lock_lat_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end
`endif

    // Strobes and acks decode from the state register so a reset drops them at once.
    always_comb begin
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_wen   = (state_q == ACCESS) &&  wen_q;
        bus.mem_ren   = (state_q == ACCESS) && !wen_q;
        bus.m0_ack    = (state_q == RESP) && !gid_q;
        bus.m1_ack    = (state_q == RESP) &&  gid_q;
        bus.m0_rdata  = m0_rdata_q;
        bus.m1_rdata  = m1_rdata_q;
        bus.grant_id  = gid_q;
        bus.cpu_stall = 1'b0;
        if (state_q == IDLE) begin
            bus.cpu_stall = bus.m0_req && win_valid && win_id;
        end else begin
            bus.cpu_stall = gid_q;
        end
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_stump_mem_arbiter.sv
// Directed bench for stump_mem_arbiter; covers the round-robin and, when built with
// STUMP_ARB_LOCK_EN, the locked-burst grant order.
module tb_stump_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state_dbg;

    int total = 0;
    int bad   = 0;

    logic [0:0]        exp_q[$];
    logic [DATA_W-1:0] exp_r0;
    logic [DATA_W-1:0] exp_r1;
    logic              g;
    int                w;

    stump_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    stump_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Memory model: combinational read, 0x0010 holds 0xBEEF, every other word is ~addr.
    assign bus.mem_rdata = (bus.mem_addr == 16'h0010) ? 16'hBEEF : ~bus.mem_addr;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_m0(input logic req, input logic wen, input logic [15:0] addr,
                            input logic [15:0] wdata);
        bus.m0_req   = req;
        bus.m0_wen   = wen;
        bus.m0_addr  = addr;
        bus.m0_wdata = wdata;
    endtask

    task automatic drive_m1(input logic req, input logic wen, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic lock);
        bus.m1_req   = req;
        bus.m1_wen   = wen;
        bus.m1_addr  = addr;
        bus.m1_wdata = wdata;
        bus.m1_lock  = lock;
    endtask

    initial begin
        rst = 1'b1;
        drive_m0(1'b0, 1'b0, 16'h0000, 16'h0000);
        drive_m1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);

        // reset state
        @(negedge clk);
        check("rst_state",     32'(state_dbg),     0);
        check("rst_m0_ack",    32'(bus.m0_ack),    0);
        check("rst_m1_ack",    32'(bus.m1_ack),    0);
        check("rst_mem_wen",   32'(bus.mem_wen),   0);
        check("rst_mem_ren",   32'(bus.mem_ren),   0);
        check("rst_mem_addr",  32'(bus.mem_addr),  0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
        check("rst_m0_rdata",  32'(bus.m0_rdata),  0);
        check("rst_m1_rdata",  32'(bus.m1_rdata),  0);
        check("rst_stall",     32'(bus.cpu_stall), 0);
        check("rst_grant",     32'(bus.grant_id),  0);
        rst = 1'b0;

        // m0 read of 0x0010
        drive_m0(1'b1, 1'b0, 16'h0010, 16'h0000);
        #1;
        check("t1_idle_stall", 32'(bus.cpu_stall), 0);
        @(negedge clk);
        check("t1_acc_state", 32'(state_dbg),    1);
        check("t1_acc_ren",   32'(bus.mem_ren),  1);
        check("t1_acc_wen",   32'(bus.mem_wen),  0);
        check("t1_acc_addr",  32'(bus.mem_addr), 32'h0010);
        check("t1_acc_grant", 32'(bus.grant_id), 0);
        @(negedge clk);
        check("t1_resp_ack0",  32'(bus.m0_ack),   1);
        check("t1_resp_ack1",  32'(bus.m1_ack),   0);
        check("t1_resp_rdata", 32'(bus.m0_rdata), 32'hBEEF);
        check("t1_resp_ren",   32'(bus.mem_ren),  0);
        drive_m0(1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check("t1_post_ack0",  32'(bus.m0_ack),   0);
        check("t1_post_rdata", 32'(bus.m0_rdata), 32'hBEEF);
        check("t1_post_state", 32'(state_dbg),    0);

        // m1 write 0x1234 to 0x0200
        drive_m1(1'b1, 1'b1, 16'h0200, 16'h1234, 1'b0);
        @(negedge clk);
        check("t2_acc_wen",   32'(bus.mem_wen),   1);
        check("t2_acc_ren",   32'(bus.mem_ren),   0);
        check("t2_acc_addr",  32'(bus.mem_addr),  32'h0200);
        check("t2_acc_wdata", 32'(bus.mem_wdata), 32'h1234);
        check("t2_acc_stall", 32'(bus.cpu_stall), 1);
        check("t2_acc_grant", 32'(bus.grant_id),  1);
        @(negedge clk);
        check("t2_resp_ack1",   32'(bus.m1_ack),    1);
        check("t2_resp_ack0",   32'(bus.m0_ack),    0);
        check("t2_resp_wen",    32'(bus.mem_wen),   0);
        check("t2_resp_stall",  32'(bus.cpu_stall), 1);
        check("t2_resp_m1rd",   32'(bus.m1_rdata),  0);
        check("t2_resp_m0rd",   32'(bus.m0_rdata),  32'hBEEF);
        drive_m1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        check("t2_post_stall", 32'(bus.cpu_stall), 0);
        check("t2_post_ack1",  32'(bus.m1_ack),    0);
        check("t2_post_grant", 32'(bus.grant_id),  1);

        // both masters reading continuously from reset: 0,1,0,1,0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_r0 = 16'h0000;
        exp_r1 = 16'h0000;
        exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        drive_m0(1'b1, 1'b0, 16'h0020, 16'h0000);
        drive_m1(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k == 0) #1;
            else @(negedge clk);
            g = exp_q.pop_front();
            check($sformatf("t3_idle_state_%0d", k), 32'(state_dbg),     0);
            check($sformatf("t3_idle_stall_%0d", k), 32'(bus.cpu_stall), 32'(g));
            @(negedge clk);
            check($sformatf("t3_acc_grant_%0d", k), 32'(bus.grant_id),  32'(g));
            check($sformatf("t3_acc_ren_%0d", k),   32'(bus.mem_ren),   1);
            check($sformatf("t3_acc_addr_%0d", k),  32'(bus.mem_addr),  g ? 32'h0030 : 32'h0020);
            check($sformatf("t3_acc_stall_%0d", k), 32'(bus.cpu_stall), 32'(g));
            @(negedge clk);
            if (g) exp_r1 = 16'hFFCF;
            else   exp_r0 = 16'hFFDF;
            check($sformatf("t3_resp_ack0_%0d", k), 32'(bus.m0_ack),   32'(!g));
            check($sformatf("t3_resp_ack1_%0d", k), 32'(bus.m1_ack),   32'(g));
            check($sformatf("t3_resp_rd0_%0d", k),  32'(bus.m0_rdata), 32'(exp_r0));
            check($sformatf("t3_resp_rd1_%0d", k),  32'(bus.m1_rdata), 32'(exp_r1));
        end

        // reset during the ACCESS cycle of an m0 read (last was m0 before the reset)
        drive_m1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        drive_m0(1'b1, 1'b0, 16'h0050, 16'h0000);
        @(negedge clk);
        check("t4_idle_state", 32'(state_dbg), 0);
        @(negedge clk);
        check("t4_acc_ren",  32'(bus.mem_ren),  1);
        check("t4_acc_addr", 32'(bus.mem_addr), 32'h0050);
        rst = 1'b1;
        #1;
        check("t4_rst_ren",   32'(bus.mem_ren), 0);
        check("t4_rst_state", 32'(state_dbg),   0);
        check("t4_rst_ack0",  32'(bus.m0_ack),  0);
        drive_m1(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0);
        @(negedge clk);
        check("t4_held_ack0",  32'(bus.m0_ack),  0);
        check("t4_held_state", 32'(state_dbg),   0);
        check("t4_held_ren",   32'(bus.mem_ren), 0);
        rst = 1'b0;
        @(negedge clk);
        check("t4_tie_grant", 32'(bus.grant_id), 0);
        check("t4_tie_addr",  32'(bus.mem_addr), 32'h0050);
        @(negedge clk);
        check("t4_resp_ack0",  32'(bus.m0_ack),   1);
        check("t4_resp_rdata", 32'(bus.m0_rdata), 32'hFFAF);
        drive_m0(1'b0, 1'b0, 16'h0000, 16'h0000);
        drive_m1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);

        // m1 issues three writes with lock 1,1,0 while m0 keeps reading 0x0060
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`ifdef STUMP_ARB_LOCK_EN
        exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
        exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
`else
        exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
`endif
        w = 0;
        drive_m0(1'b1, 1'b0, 16'h0060, 16'h0000);
        drive_m1(1'b1, 1'b1, 16'h0300, 16'h1000, 1'b1);
        for (int k = 0; k < 6; k++) begin
            if (k == 0) #1;
            else @(negedge clk);
            g = exp_q.pop_front();
            check($sformatf("t5_idle_stall_%0d", k), 32'(bus.cpu_stall), 32'(g));
            @(negedge clk);
            check($sformatf("t5_acc_grant_%0d", k), 32'(bus.grant_id),  32'(g));
            check($sformatf("t5_acc_stall_%0d", k), 32'(bus.cpu_stall), 32'(g));
            check($sformatf("t5_acc_wen_%0d", k),   32'(bus.mem_wen),   32'(g));
            check($sformatf("t5_acc_ren_%0d", k),   32'(bus.mem_ren),   32'(!g));
            check($sformatf("t5_acc_addr_%0d", k),  32'(bus.mem_addr),
                  g ? 32'(16'h0300 + 16'(w)) : 32'h0060);
            if (g) check($sformatf("t5_acc_wdata_%0d", k), 32'(bus.mem_wdata),
                         32'(16'h1000 + 16'(w)));
            @(negedge clk);
            check($sformatf("t5_resp_ack0_%0d", k), 32'(bus.m0_ack), 32'(!g));
            check($sformatf("t5_resp_ack1_%0d", k), 32'(bus.m1_ack), 32'(g));
            if (!g) check($sformatf("t5_resp_rd0_%0d", k), 32'(bus.m0_rdata), 32'hFF9F);
            if (g) begin
                w++;
                if (w == 3) drive_m1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
                else drive_m1(1'b1, 1'b1, 16'h0300 + 16'(w), 16'h1000 + 16'(w), (w == 2) ? 1'b0 : 1'b1);
            end
        end
        check("t5_m1_writes_done", 32'(w), 3);
        drive_m0(1'b0, 1'b0, 16'h0000, 16'h0000);
        drive_m1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
